// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer controller and its prescaler.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
  localparam int unsigned DEFAULT_SEC_W  = 8;

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// User-control / status bundle between the key/switch front end and the countdown controller.
interface countdown_timer_ctrl_if
  import timer_pkg::*;
#(
  parameter int unsigned SEC_W = DEFAULT_SEC_W
);

  // Controls are plain levels sampled on every rising clock edge; there is no
  // valid/ready handshake. Status outputs are registered; tick and done are
  // single-cycle pulses.
  logic             start;
  logic             stop;
  logic             clear;
  logic [SEC_W-1:0] load_val;
  logic [SEC_W-1:0] remaining;
  logic             busy;
  logic             paused;
  logic             tick;
  logic             done;
  state_t           dbg_state;

  modport master (
    output start, stop, clear, load_val,
    input  remaining, busy, paused, tick, done, dbg_state
  );

  modport slave (
    input  start, stop, clear, load_val,
    output remaining, busy, paused, tick, done, dbg_state
  );

endinterface

// File: rtl/tick_prescaler.sv
// Gated seconds prescaler: counts 0..CLK_HZ-1 while enabled and flags the wrap cycle.
module tick_prescaler #(
  parameter int unsigned CLK_HZ = timer_pkg::DEFAULT_CLK_HZ
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned         CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // The count is held while disabled so a paused partial second survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign wrap = en && w_at_last;

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown controller: loads seconds, runs/pauses/resumes/clears a gated prescaler, reports status.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
  parameter int unsigned SEC_W  = DEFAULT_SEC_W
) (
  input  logic                   clock,
  input  logic                   reset,
  countdown_timer_ctrl_if.slave  bus
);

  state_t           r_state;
  logic [SEC_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_paused;
  logic             r_tick;
  logic             r_done;

  logic w_wrap;
  logic w_accept_load;
  logic w_pre_en;
  logic w_pre_clr;
  logic w_last_sec;

  assign w_accept_load = (r_state == S_IDLE) && bus.start && !bus.clear &&
                         (bus.load_val != '0);
  assign w_pre_en      = (r_state == S_RUN);
  assign w_pre_clr     = bus.clear || w_accept_load;
  assign w_last_sec    = (r_remaining <= SEC_W'(1));

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (w_pre_en),
    .clr   (w_pre_clr),
    .wrap  (w_wrap)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (bus.clear) begin
        r_state     <= S_IDLE;
        r_remaining <= '0;
        r_busy      <= 1'b0;
        r_paused    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.load_val != '0) begin
                r_state     <= S_RUN;
                r_remaining <= bus.load_val;
                r_busy      <= 1'b1;
                r_paused    <= 1'b0;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // A wrap edge always decrements; expiry outranks a coincident stop.
            if (w_wrap) begin
              r_tick <= 1'b1;
              if (w_last_sec) begin
                r_state     <= S_IDLE;
                r_remaining <= '0;
                r_busy      <= 1'b0;
                r_paused    <= 1'b0;
                r_done      <= 1'b1;
              end else begin
                r_remaining <= r_remaining - 1'b1;
                if (bus.stop) begin
                  r_state  <= S_PAUSED;
                  r_paused <= 1'b1;
                end
              end
            end else if (bus.stop) begin
              r_state  <= S_PAUSED;
              r_paused <= 1'b1;
            end
          end
          S_PAUSED: begin
            if (bus.start) begin
              r_state  <= S_RUN;
              r_paused <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_paused    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.remaining = r_remaining;
  assign bus.busy      = r_busy;
  assign bus.paused    = r_paused;
  assign bus.tick      = r_tick;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with CLK_HZ = 4, SEC_W = 4.
module tb_countdown_timer_ctrl;
  import timer_pkg::*;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned SEC_W  = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  countdown_timer_ctrl_if #(.SEC_W(SEC_W)) bus ();

  countdown_timer_ctrl #(
    .CLK_HZ (CLK_HZ),
    .SEC_W  (SEC_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Observed status packed as {remaining, busy, paused, tick, done}.
  logic [SEC_W+3:0] w_obs;
  assign w_obs = {bus.remaining, bus.busy, bus.paused, bus.tick, bus.done};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench just after edge E, where start was accepted.
  task automatic start_run(input logic [SEC_W-1:0] v);
    bus.load_val = v;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
  endtask

  task automatic test_reset();
    logic [SEC_W+3:0] exp;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_initial: got %b state %0d expected all 0 state 0", w_obs, bus.dbg_state);
    end
    step(); step(); step();
    reset = 1'b1;
    step(); step();
    checks++;
    if (w_obs !== '0) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0", w_obs);
    end
    start_run(4'd5);
    for (int k = 1; k <= 6; k++) step();
    exp = {4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL reset_prerun: got %b expected %b", w_obs, exp);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_async: got %b state %0d expected all 0 state 0", w_obs, bus.dbg_state);
    end
    step(); step(); step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
        errors++;
        $display("FAIL reset_after k=%0d: got %b state %0d expected all 0 state 0", k, w_obs, bus.dbg_state);
      end
    end
  endtask

  task automatic test_countdown();
    logic [SEC_W+3:0] exp;
    start_run(4'd3);
    exp = {4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL countdown_load: got %b expected %b", w_obs, exp);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp = {4'(3 - k / 4), 1'(k < 12), 1'b0, 1'(k % 4 == 0), 1'(k == 12)};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL countdown E+%0d: got %b expected %b", k, w_obs, exp);
      end
    end
    step();
    checks++;
    if (w_obs !== '0) begin
      errors++;
      $display("FAIL countdown_after: got %b expected 0", w_obs);
    end
  endtask

  task automatic test_zero_load();
    logic [SEC_W+3:0] exp;
    start_run(4'd0);
    exp = {4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL zero_load_done: got %b expected %b", w_obs, exp);
    end
    step();
    checks++;
    if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL zero_load_after: got %b state %0d expected 0 state 0", w_obs, bus.dbg_state);
    end
  endtask

  task automatic test_pause_resume();
    logic [SEC_W+3:0] exp;
    start_run(4'd2);
    step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      exp = {4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL pause E+%0d: got %b expected %b", k, w_obs, exp);
      end
      if (k == 6) bus.start = 1'b1;
      step();
    end
    bus.start = 1'b0;
    for (int k = 7; k <= 13; k++) begin
      if (k < 9)       exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      else if (k == 9) exp = {4'd1, 1'b1, 1'b0, 1'b1, 1'b0};
      else if (k < 13) exp = {4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
      else             exp = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL resume E+%0d: got %b expected %b", k, w_obs, exp);
      end
      if (k < 13) step();
    end
    step();
  endtask

  task automatic test_clear();
    logic [SEC_W+3:0] exp;
    start_run(4'd3);
    for (int k = 1; k <= 4; k++) step();
    exp = {4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL clear_pre E+4: got %b expected %b", w_obs, exp);
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++;
    if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL clear E+5: got %b state %0d expected 0 state 0", w_obs, bus.dbg_state);
    end
    for (int k = 6; k <= 17; k++) begin
      step();
      checks++;
      if (w_obs !== '0) begin
        errors++;
        $display("FAIL clear_quiet E+%0d: got %b expected 0", k, w_obs);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [SEC_W+3:0] exp;
    start_run(4'd3);
    step(); step(); step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    exp = {4'd2, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (w_obs !== exp || bus.dbg_state !== S_PAUSED) begin
      errors++;
      $display("FAIL stop_on_wrap: got %b state %0d expected %b state %0d", w_obs, bus.dbg_state, exp, S_PAUSED);
    end
    step(); step();
    exp = {4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL stop_on_wrap_hold: got %b expected %b", w_obs, exp);
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;

    bus.load_val = 4'd5;
    bus.start    = 1'b1;
    bus.clear    = 1'b1;
    step();
    bus.start    = 1'b0;
    bus.clear    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (w_obs !== '0 || bus.dbg_state !== S_IDLE) begin
        errors++;
        $display("FAIL clear_start_idle k=%0d: got %b state %0d expected 0 state 0", k, w_obs, bus.dbg_state);
      end
      step();
    end

    start_run(4'd3);
    step();
    bus.load_val = 4'd9;
    bus.start    = 1'b1;
    for (int k = 2; k <= 12; k++) begin
      step();
      if (k == 4) bus.start = 1'b0;
      exp = {4'(3 - k / 4), 1'(k < 12), 1'b0, 1'(k % 4 == 0), 1'(k == 12)};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL start_in_run E+%0d: got %b expected %b", k, w_obs, exp);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [SEC_W+3:0] exp;
    start_run(4'd1);
    step(); step(); step(); step();
    exp = {4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL b2b_expiry: got %b expected %b", w_obs, exp);
    end
    start_run(4'd2);
    exp = {4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL b2b_reload: got %b expected %b", w_obs, exp);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = {4'(2 - k / 4), 1'b1, 1'b0, 1'(k == 4), 1'b0};
      checks++;
      if (w_obs !== exp) begin
        errors++;
        $display("FAIL b2b_run E+%0d: got %b expected %b", k, w_obs, exp);
      end
    end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.clear    = 1'b0;
    bus.load_val = '0;
    test_reset();
    test_countdown();
    test_zero_load();
    test_pause_resume();
    test_clear();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
